// File: rtl/vmx_result_collector.sv
// rtl/vmx_result_collector.sv - deskews systolic column sums, requantizes them and buffers the vectors in an output FIFO
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   in_valid        column-0 result valid; column j is valid j cycles later
//   in_simd_mode    1 = two 8-bit lanes per column, 0 = one 16-bit result
//   shift_amt       rounding right-shift amount, sampled with in_valid
//   col_sum         bottom-row sums, column j at [j*PRODUCT_BITLEN +: PRODUCT_BITLEN]
//   out_valid/out_ready/out_data   output stream of requantized vectors (FIFO head)
//   fifo_count      occupied FIFO entries
//   overflow        sticky: a vector was dropped on a full FIFO
//   sat_flag        sticky: some lane was clamped
module vmx_result_collector #(
    parameter int NUM_COLS       = 8,
    parameter int PRODUCT_BITLEN = 32,
    parameter int OUT_BITLEN     = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    input  logic                             in_simd_mode,
    input  logic [4:0]                       shift_amt,
    input  logic [NUM_COLS*PRODUCT_BITLEN-1:0] col_sum,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_COLS*OUT_BITLEN-1:0]   out_data,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
    output logic                             overflow,
    output logic                             sat_flag
);

    localparam int PB  = PRODUCT_BITLEN;
    localparam int OB  = OUT_BITLEN;
    localparam int LB  = PB / 2;
    localparam int HB  = OB / 2;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int DLY = NUM_COLS - 1;
    localparam int VW  = NUM_COLS * OB;

    // Round-half-up, arithmetic shift, saturate. MSB of the result is the clamp flag.
    function automatic logic [OB:0] rq_full(input logic [PB-1:0] x, input logic [4:0] sh);
        logic signed [PB:0] s;
        s = $signed({x[PB-1], x});
        if (sh != 5'd0) s = s + ((PB+1)'(1) << (sh - 5'd1));
        s = s >>> sh;
        // The value fits when every bit above the output sign bit matches it.
        if ((&s[PB:OB-1]) || (~|s[PB:OB-1])) return {1'b0, s[OB-1:0]};
        return {1'b1, s[PB], {(OB-1){~s[PB]}}};
    endfunction

    function automatic logic [HB:0] rq_lane(input logic [LB-1:0] x, input logic [4:0] sh);
        logic signed [LB:0] s;
        logic [4:0]         c;
        c = (sh > 5'(LB-1)) ? 5'(LB-1) : sh;
        s = $signed({x[LB-1], x});
        if (c != 5'd0) s = s + ((LB+1)'(1) << (c - 5'd1));
        s = s >>> c;
        if ((&s[LB:HB-1]) || (~|s[LB:HB-1])) return {1'b0, s[HB-1:0]};
        return {1'b1, s[LB], {(HB-1){~s[LB]}}};
    endfunction

    // ---------------- control pipeline (aligns with the last column) ----------------
    logic       w_ctl_valid;
    logic       w_ctl_simd;
    logic [4:0] w_ctl_shift;

    if (DLY == 0) begin : g_ctl_direct
        assign w_ctl_valid = in_valid;
        assign w_ctl_simd  = in_simd_mode;
        assign w_ctl_shift = shift_amt;
    end else begin : g_ctl_pipe
        logic       r_vld [DLY];
        logic       r_mode[DLY];
        logic [4:0] r_sh  [DLY];
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int k = 0; k < DLY; k++) begin
                    r_vld[k]  <= 1'b0;
                    r_mode[k] <= 1'b0;
                    r_sh[k]   <= 5'd0;
                end
            end else begin
                r_vld[0]  <= in_valid;
                r_mode[0] <= in_simd_mode;
                r_sh[0]   <= shift_amt;
                for (int k = 1; k < DLY; k++) begin
                    r_vld[k]  <= r_vld[k-1];
                    r_mode[k] <= r_mode[k-1];
                    r_sh[k]   <= r_sh[k-1];
                end
            end
        end
        assign w_ctl_valid = r_vld[DLY-1];
        assign w_ctl_simd  = r_mode[DLY-1];
        assign w_ctl_shift = r_sh[DLY-1];
    end

    // ---------------- per-column deskew and requant ----------------
    logic [VW-1:0]       w_rq_vec;
    logic [NUM_COLS-1:0] w_col_sat;

    for (genvar gj = 0; gj < NUM_COLS; gj++) begin : g_col
        localparam int D = NUM_COLS - 1 - gj;
        logic [PB-1:0] w_aligned;
        logic [OB:0]   w_f;
        logic [HB:0]   w_hi;
        logic [HB:0]   w_lo;

        if (D == 0) begin : g_nodly
            assign w_aligned = col_sum[gj*PB +: PB];
        end else begin : g_dly
            logic [PB-1:0] r_sr [D];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int k = 0; k < D; k++) r_sr[k] <= '0;
                end else begin
                    r_sr[0] <= col_sum[gj*PB +: PB];
                    for (int k = 1; k < D; k++) r_sr[k] <= r_sr[k-1];
                end
            end
            assign w_aligned = r_sr[D-1];
        end

        assign w_f  = rq_full(w_aligned, w_ctl_shift);
        assign w_hi = rq_lane(w_aligned[PB-1:LB], w_ctl_shift);
        assign w_lo = rq_lane(w_aligned[LB-1:0], w_ctl_shift);
        assign w_rq_vec[gj*OB +: OB] = w_ctl_simd ? {w_hi[HB-1:0], w_lo[HB-1:0]} : w_f[OB-1:0];
        assign w_col_sat[gj]         = w_ctl_simd ? (w_hi[HB] | w_lo[HB]) : w_f[OB];
    end

    logic          r_rq_valid;
    logic [VW-1:0] r_rq_data;
    logic          r_sat_flag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rq_valid <= 1'b0;
            r_rq_data  <= '0;
            r_sat_flag <= 1'b0;
        end else begin
            r_rq_valid <= w_ctl_valid;
            r_rq_data  <= w_rq_vec;
            r_sat_flag <= r_sat_flag | (w_ctl_valid & (|w_col_sat));
        end
    end

    // ---------------- output FIFO ----------------
    logic [VW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic          w_full;
    logic          w_pop;
    logic          w_push;

    assign w_full = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_pop  = (r_count != '0) && out_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_push = r_rq_valid && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_rq_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            if (r_rq_valid && !w_push) r_overflow <= 1'b1;
        end
    end

    assign out_valid  = (r_count != '0);
    assign out_data   = out_valid ? r_mem[r_rd_ptr] : '0;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign sat_flag   = r_sat_flag;

endmodule

// File: tb/tb_vmx_result_collector.sv
// tb/tb_vmx_result_collector.sv - directed self-checking bench for vmx_result_collector
module tb_vmx_result_collector;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_simd_mode;
    logic [4:0]   shift_amt;
    logic [127:0] col_sum;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic [2:0]   fifo_count;
    logic         overflow;
    logic         sat_flag;

    int n_checks = 0;
    int n_errors = 0;

    logic [127:0] hist [4];

    always #5 clk = ~clk;

    vmx_result_collector #(
        .NUM_COLS(4), .PRODUCT_BITLEN(32), .OUT_BITLEN(16), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_simd_mode(in_simd_mode),
        .shift_amt(shift_amt), .col_sum(col_sum), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .fifo_count(fifo_count),
        .overflow(overflow), .sat_flag(sat_flag)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: column j of the bus carries the vector issued j cycles ago.
    task automatic tick(input logic v, input logic m, input logic [4:0] sh, input logic [127:0] s);
        for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
        hist[0]      = v ? s : '0;
        in_valid     = v;
        in_simd_mode = m;
        shift_amt    = sh;
        for (int j = 0; j < 4; j++) col_sum[j*32 +: 32] = hist[j][j*32 +: 32];
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 5'd0, '0);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 12) begin
            idle(1);
            n++;
        end
        check({tag, "_arrive"}, {63'd0, out_valid}, 64'd1);
    endtask

    task automatic pop_check(input string tag, input logic [63:0] exp);
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_data"}, out_data, exp);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b0; in_valid = 1'b0; in_simd_mode = 1'b0;
        shift_amt = '0; col_sum = '0;
        for (int k = 0; k < 4; k++) hist[k] = '0;
        idle(2);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_data", out_data, 64'd0);
        check("rst_count", {61'd0, fifo_count}, 64'd0);
        check("rst_ovf", {63'd0, overflow}, 64'd0);
        check("rst_sat", {63'd0, sat_flag}, 64'd0);
        rst_n = 1'b1;
        idle(1);

        // 1: plain 16-bit pass-through and latency
        tick(1'b1, 1'b0, 5'd0, {32'hFFFFFE70, 32'h0000012C, 32'hFFFFFF38, 32'h00000064});
        idle(3);
        check("t1_early", {63'd0, out_valid}, 64'd0);
        idle(1);
        check("t1_count", {61'd0, fifo_count}, 64'd1);
        pop_check("t1", 64'hFE70_012C_FF38_0064);
        check("t1_empty", {63'd0, out_valid}, 64'd0);

        // 2: rounding shift, then saturation at both rails
        tick(1'b1, 1'b0, 5'd4, {32'hFFFFFFF8, 32'h00000100, 32'hFFFFFFE8, 32'h00000018});
        wait_valid("t2a");
        pop_check("t2a", 64'h0000_0010_FFFF_0002);
        check("t2_nosat", {63'd0, sat_flag}, 64'd0);
        tick(1'b1, 1'b0, 5'd0, {32'h00007FFF, 32'hFFFF8000, 32'h80000000, 32'h00100000});
        wait_valid("t2b");
        pop_check("t2b", 64'h7FFF_8000_8000_7FFF);
        check("t2_sat", {63'd0, sat_flag}, 64'd1);

        // 3: SIMD lanes, including shift clamped to 15
        tick(1'b1, 1'b1, 5'd1, {32'h00000000, 32'hFED40000, 32'h000A0003, 32'h012DFFFB});
        tick(1'b1, 1'b1, 5'd20, {4{32'h4000C000}});
        wait_valid("t3a");
        pop_check("t3a", 64'h0000_8000_0502_7FFE);
        pop_check("t3b", {4{16'h0100}});

        // 5: full FIFO with simultaneous push and pop
        for (int v = 11; v <= 14; v++) tick(1'b1, 1'b0, 5'd0, {4{v[31:0]}});
        tick(1'b1, 1'b0, 5'd0, {4{32'd15}});
        idle(3);
        check("t5_full", {61'd0, fifo_count}, 64'd4);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        check("t5_count", {61'd0, fifo_count}, 64'd4);
        check("t5_ovf", {63'd0, overflow}, 64'd0);
        for (int v = 12; v <= 15; v++) pop_check("t5_drain", {4{v[15:0]}});

        // 5b: alternating modes back-to-back
        tick(1'b1, 1'b0, 5'd0, {4{32'h00000123}});
        tick(1'b1, 1'b1, 5'd0, {4{32'h0005FFFE}});
        tick(1'b1, 1'b0, 5'd1, {4{32'h00000003}});
        wait_valid("t5m");
        pop_check("t5m_a", {4{16'h0123}});
        pop_check("t5m_b", {4{16'h05FE}});
        pop_check("t5m_c", {4{16'h0002}});

        // 4: overflow drops the fifth vector
        for (int v = 21; v <= 25; v++) tick(1'b1, 1'b0, 5'd0, {4{v[31:0]}});
        idle(6);
        check("t4_count", {61'd0, fifo_count}, 64'd4);
        check("t4_ovf", {63'd0, overflow}, 64'd1);
        for (int v = 21; v <= 24; v++) pop_check("t4_drain", {4{v[15:0]}});
        check("t4_gone", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        check("t4_pop_empty", {61'd0, fifo_count}, 64'd0);

        // 6: reset with vectors buffered and in flight
        tick(1'b1, 1'b0, 5'd0, {4{32'd31}});
        tick(1'b1, 1'b0, 5'd0, {4{32'd32}});
        idle(5);
        check("t6_buf", {61'd0, fifo_count}, 64'd2);
        tick(1'b1, 1'b0, 5'd0, {4{32'd33}});
        tick(1'b1, 1'b0, 5'd0, {4{32'd34}});
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        check("t6_valid", {63'd0, out_valid}, 64'd0);
        check("t6_count", {61'd0, fifo_count}, 64'd0);
        check("t6_data", out_data, 64'd0);
        check("t6_ovf", {63'd0, overflow}, 64'd0);
        check("t6_sat", {63'd0, sat_flag}, 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            idle(1);
            check("t6_stale", {63'd0, out_valid}, 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vmx_result_collector.md
Name: vmx_result_collector

Overview:
- Sits directly below the bottom row of the vector-matrix systolic PE array and consumes each column's `sum_out`.
- Column j's result arrives j cycles after column 0. The block deskews the columns into one aligned vector and requantizes each column result with round-and-saturate.
  - 16-bit mode: 32-bit sum to signed 16.
  - SIMD mode: two 16-bit lanes, each to signed 8, packed into 16 bits.
- Results are buffered in a small FIFO and drained over a valid/ready stream to the DMA/AXI output path.

Parameters:
- NUM_COLS, 8, number of PE columns; must be >= 1.
- PRODUCT_BITLEN, 32, width of each column sum; must be even.
- OUT_BITLEN, 16, width per column of the output word; equals PRODUCT_BITLEN/2.
- FIFO_DEPTH, 4, number of output vectors buffered; power of two, >= 2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  column-0 result valid this cycle. Column j is valid j cycles later.
- in_simd_mode  input  1  mode of the result flagged by in_valid: 1 = 2x8-bit lanes, 0 = 16-bit.
- shift_amt  input  5  right-shift amount, sampled with in_valid.
- col_sum  input  NUM_COLS*PRODUCT_BITLEN  bottom-row sums; column j is at [j*PRODUCT_BITLEN +: PRODUCT_BITLEN].
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head.
- out_data  output  NUM_COLS*OUT_BITLEN  requantized vector; column j is at [j*OUT_BITLEN +: OUT_BITLEN].
- fifo_count  output  clog2(FIFO_DEPTH)+1  occupied entries.
- overflow  output  1  sticky: a result was dropped because the FIFO was full.
- sat_flag  output  1  sticky: any lane saturated.

Behaviour:
- Reset:
  - out_valid=0, out_data=0, fifo_count=0, overflow=0, sat_flag=0.
  - All delay registers, valid/mode/shift pipelines and FIFO pointers are cleared.
  - A reset mid-operation discards all in-flight and buffered results; there is no partial drain.
- Deskew:
  - Column j passes through NUM_COLS-1-j registers; column NUM_COLS-1 has zero delay.
  - in_valid, in_simd_mode and shift_amt pass through a NUM_COLS-1 stage pipeline, so they align with the deskewed vector.
  - The deskew pipeline never stalls, because the array cannot be backpressured.
- Requant stage: one register stage, computed per column.
  - 16-bit mode: s = signed 32-bit sum, computed in 33 bits. If shift_amt>0, s += 1<<(shift_amt-1), then arithmetic >> shift_amt. Saturate to [-32768, 32767].
  - SIMD mode: each 16-bit half is treated as a signed lane and computed in 17 bits, with the same round/shift. shift_amt is clamped to 15. Saturate to [-128, 127]. Upper lane goes to [15:8], lower lane to [7:0].
  - sat_flag is set on any clamp and stays set until reset.
- Latency:
  - in_valid is sampled at edge E. The requantized vector is written to the FIFO at edge E+NUM_COLS.
  - If the FIFO was empty, out_valid rises after that edge.
- FIFO:
  - Write when the requant stage is valid. Pop when out_valid && out_ready.
  - out_data shows the head entry, stable while out_valid && !out_ready.
  - Full with push and no pop: drop the new vector, set overflow (sticky), fifo_count unchanged.
  - Full with push and pop in the same cycle: both occur, no overflow, count unchanged.
  - Empty with push only: count goes to 1. A pop while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Back-to-back: in_valid may be high on consecutive cycles with differing modes and shifts; each vector uses its own sampled mode and shift.

Test Plan:
1. NUM_COLS=4, 16-bit mode, shift=0, column j sums 100,-200,300,-400 presented with the j-cycle skew, out_ready=1 -> out_valid after 4 edges; out_data lanes = 100,-200,300,-400.
2. 16-bit mode, shift=4, sums 0x00000018 and 0xFFFFFFE8 -> 2 and -1 (+/-24+8 >> 4). Sum 0x00100000 with shift=0 -> 32767 and sat_flag=1.
3. SIMD mode, shift=1, column sum {16'sd301, -16'sd5} -> upper lane 127 (saturated), lower lane -2 ((-5+1)>>1); out_data column = 16'h7FFE.
4. out_ready=0, push 5 vectors with FIFO_DEPTH=4 -> fifo_count=4, overflow=1, the first 4 vectors drain in order once out_ready=1, and vector 5 is absent.
5. FIFO full, push and pop in the same cycle -> overflow stays 0 and count stays 4. Alternating modes back-to-back -> each output uses its own mode.
6. Assert rst_n=0 for one cycle while 2 vectors are in flight and 2 are buffered -> next cycle out_valid=0, fifo_count=0, flags=0, and no stale vector ever appears.
